// File: rtl/homelab_keymatrix_pkg.sv
// Shared types and the PS/2 set-2 scancode to Homelab matrix table.
package homelab_kbd_pkg;

  localparam int ROW_W = 4;
  localparam int COL_W = 3;

  typedef struct packed {
    logic             hit;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } key_pos_t;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [3:0]       cnt;
    logic             rel_pend;
  } hold_slot_t;

  // Builds a mapped matrix position.
  function automatic key_pos_t kp(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    key_pos_t k;
    k.hit = 1'b1;
    k.row = row;
    k.col = col;
    return k;
  endfunction

  // {extended, code} -> matrix position; anything not listed is ignored.
  function automatic key_pos_t map_key(input logic ext, input logic [7:0] code);
    key_pos_t k;
    k = '0;
    case ({ext, code})
      // row 0: cursor keys, space, enter
      9'h172: k = kp(4'd0, 3'd0);
      9'h175: k = kp(4'd0, 3'd1);
      9'h16B: k = kp(4'd0, 3'd2);
      9'h174: k = kp(4'd0, 3'd3);
      9'h029: k = kp(4'd0, 3'd4);
      9'h05A: k = kp(4'd0, 3'd5);
      // row 1: both shifts share one bit, then ctrl and alt
      9'h012: k = kp(4'd1, 3'd0);
      9'h059: k = kp(4'd1, 3'd0);
      9'h014: k = kp(4'd1, 3'd1);
      9'h011: k = kp(4'd1, 3'd2);
      // row 2: digits 0-7
      9'h045: k = kp(4'd2, 3'd0);
      9'h016: k = kp(4'd2, 3'd1);
      9'h01E: k = kp(4'd2, 3'd2);
      9'h026: k = kp(4'd2, 3'd3);
      9'h025: k = kp(4'd2, 3'd4);
      9'h02E: k = kp(4'd2, 3'd5);
      9'h036: k = kp(4'd2, 3'd6);
      9'h03D: k = kp(4'd2, 3'd7);
      // row 3: 8, 9 and punctuation
      9'h03E: k = kp(4'd3, 3'd0);
      9'h046: k = kp(4'd3, 3'd1);
      9'h04C: k = kp(4'd3, 3'd2);
      9'h052: k = kp(4'd3, 3'd3);
      9'h041: k = kp(4'd3, 3'd4);
      9'h04E: k = kp(4'd3, 3'd5);
      9'h049: k = kp(4'd3, 3'd6);
      9'h04A: k = kp(4'd3, 3'd7);
      // row 4: A-H
      9'h01C: k = kp(4'd4, 3'd0);
      9'h032: k = kp(4'd4, 3'd1);
      9'h021: k = kp(4'd4, 3'd2);
      9'h023: k = kp(4'd4, 3'd3);
      9'h024: k = kp(4'd4, 3'd4);
      9'h02B: k = kp(4'd4, 3'd5);
      9'h034: k = kp(4'd4, 3'd6);
      9'h033: k = kp(4'd4, 3'd7);
      // row 5: I-P
      9'h043: k = kp(4'd5, 3'd0);
      9'h03B: k = kp(4'd5, 3'd1);
      9'h042: k = kp(4'd5, 3'd2);
      9'h04B: k = kp(4'd5, 3'd3);
      9'h03A: k = kp(4'd5, 3'd4);
      9'h031: k = kp(4'd5, 3'd5);
      9'h044: k = kp(4'd5, 3'd6);
      9'h04D: k = kp(4'd5, 3'd7);
      // row 6: Q-X
      9'h015: k = kp(4'd6, 3'd0);
      9'h02D: k = kp(4'd6, 3'd1);
      9'h01B: k = kp(4'd6, 3'd2);
      9'h02C: k = kp(4'd6, 3'd3);
      9'h03C: k = kp(4'd6, 3'd4);
      9'h02A: k = kp(4'd6, 3'd5);
      9'h01D: k = kp(4'd6, 3'd6);
      9'h022: k = kp(4'd6, 3'd7);
      // row 7: Y, Z
      9'h035: k = kp(4'd7, 3'd0);
      9'h01A: k = kp(4'd7, 3'd1);
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/homelab_keymatrix_if.sv
// Key event input, CPU row select and matrix read-back between user_io side and the core.
interface homelab_keymatrix_if #(
  parameter int ROWS = 16
) ();

  logic                    KEY_STROBE;
  logic                    KEY_PRESSED;
  logic                    KEY_EXTENDED;
  logic [7:0]              KEY_CODE;
  logic                    VSYNC;
  logic [$clog2(ROWS)-1:0] SEL;
  logic [7:0]              DOUT;
  logic                    ANY_KEY;

  modport master (
    output KEY_STROBE, KEY_PRESSED, KEY_EXTENDED, KEY_CODE, VSYNC, SEL,
    input  DOUT, ANY_KEY
  );

  modport slave (
    input  KEY_STROBE, KEY_PRESSED, KEY_EXTENDED, KEY_CODE, VSYNC, SEL,
    output DOUT, ANY_KEY
  );

endinterface

// File: rtl/homelab_keymatrix_holdtab.sv
// Minimum-hold slot table: ages slots on frame ticks, matches and allocates on key events,
// and tells the matrix which bits to set or clear this cycle.
module homelab_kbd_holdtab
  import homelab_kbd_pkg::*;
#(
  parameter int HOLD_SLOTS  = 4,
  parameter int HOLD_FRAMES = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 tick,
  input  logic                                 ev_valid,
  input  logic                                 ev_make,
  input  logic [ROW_W-1:0]                     ev_row,
  input  logic [COL_W-1:0]                     ev_col,
  output logic                                 ev_set,
  output logic                                 ev_clr,
  output logic [HOLD_SLOTS-1:0]                exp_clr,
  output logic [HOLD_SLOTS-1:0][ROW_W-1:0]     exp_row,
  output logic [HOLD_SLOTS-1:0][COL_W-1:0]     exp_col
);

  localparam int         IDX_W    = (HOLD_SLOTS > 1) ? $clog2(HOLD_SLOTS) : 1;
  localparam logic [3:0] HOLD_CNT = 4'(HOLD_FRAMES);

  hold_slot_t [HOLD_SLOTS-1:0] slot_q;
  hold_slot_t [HOLD_SLOTS-1:0] slot_d;
  hold_slot_t [HOLD_SLOTS-1:0] slot_t;
  logic                        match_found;
  logic                        free_found;
  logic [IDX_W-1:0]            match_idx;
  logic [IDX_W-1:0]            free_idx;

  // Frame tick ages every slot; expired slots free up and release a pending break.
  always_comb begin
    slot_t  = slot_q;
    exp_clr = '0;
    for (int i = 0; i < HOLD_SLOTS; i++) begin
      exp_row[i] = slot_q[i].row;
      exp_col[i] = slot_q[i].col;
      if (tick && slot_q[i].valid) begin
        if (slot_q[i].cnt != 4'd0) begin
          slot_t[i].cnt = slot_q[i].cnt - 4'd1;
        end
        if (slot_t[i].cnt == 4'd0) begin
          exp_clr[i] = slot_q[i].rel_pend;
          slot_t[i]  = '0;
        end
      end
    end
  end

  // Search the aged table for this key and for the lowest free slot.
  always_comb begin
    match_found = 1'b0;
    free_found  = 1'b0;
    match_idx   = '0;
    free_idx    = '0;
    for (int i = HOLD_SLOTS - 1; i >= 0; i--) begin
      if (slot_t[i].valid && slot_t[i].row == ev_row && slot_t[i].col == ev_col) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!slot_t[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Apply the key event on top of the aged table.
  always_comb begin
    slot_d = slot_t;
    ev_set = 1'b0;
    ev_clr = 1'b0;
    if (ev_valid) begin
      if (ev_make) begin
        ev_set = 1'b1;
        if (match_found) begin
          slot_d[match_idx].cnt      = HOLD_CNT;
          slot_d[match_idx].rel_pend = 1'b0;
        end else if (free_found) begin
          slot_d[free_idx].valid    = 1'b1;
          slot_d[free_idx].row      = ev_row;
          slot_d[free_idx].col      = ev_col;
          slot_d[free_idx].cnt      = HOLD_CNT;
          slot_d[free_idx].rel_pend = 1'b0;
        end
      end else begin
        if (match_found && slot_t[match_idx].cnt != 4'd0) begin
          slot_d[match_idx].rel_pend = 1'b1;
        end else begin
          ev_clr = 1'b1;
        end
      end
    end
  end

  // Slot table state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/homelab_keymatrix.sv
// Homelab keyboard matrix: PS/2 key events in, CPU-polled active-low row columns out,
// with every press held visible for a minimum number of frames.
module homelab_keymatrix
  import homelab_kbd_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int HOLD_SLOTS  = 4,
  parameter int HOLD_FRAMES = 3
) (
  input  logic                CLK12,
  input  logic                RESET_N,
  homelab_keymatrix_if.slave  kbd
);

  logic                              rst_meta_q, rst_meta_d;
  logic                              rst_sync_q, rst_sync_d;
  logic                              vsync_q, vsync_d;
  logic [ROWS-1:0][7:0]              down_q, down_d;
  logic [7:0]                        dout_q, dout_d;
  logic                              any_key_q, any_key_d;

  key_pos_t                          key_pos;
  logic                              tick;
  logic                              ev_valid;
  logic                              ev_set;
  logic                              ev_clr;
  logic [HOLD_SLOTS-1:0]             exp_clr;
  logic [HOLD_SLOTS-1:0][ROW_W-1:0]  exp_row;
  logic [HOLD_SLOTS-1:0][COL_W-1:0]  exp_col;

  // Reset synchronizer next-state: release propagates through two flops.
  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  // Reset synchronizer: asserts asynchronously, releases on the clock.
  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  // Decode the event and detect the VSYNC rising edge against last cycle's level.
  always_comb begin
    key_pos  = map_key(kbd.KEY_EXTENDED, kbd.KEY_CODE);
    ev_valid = kbd.KEY_STROBE & key_pos.hit;
    vsync_d  = kbd.VSYNC;
    tick     = kbd.VSYNC & ~vsync_q;
  end

  homelab_kbd_holdtab #(
    .HOLD_SLOTS  (HOLD_SLOTS),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_holdtab (
    .clk      (CLK12),
    .rst_n    (rst_sync_q),
    .tick     (tick),
    .ev_valid (ev_valid),
    .ev_make  (kbd.KEY_PRESSED),
    .ev_row   (key_pos.row),
    .ev_col   (key_pos.col),
    .ev_set   (ev_set),
    .ev_clr   (ev_clr),
    .exp_clr  (exp_clr),
    .exp_row  (exp_row),
    .exp_col  (exp_col)
  );

  // Matrix next state: expiry releases first, then this cycle's key event.
  always_comb begin
    down_d = down_q;
    for (int i = 0; i < HOLD_SLOTS; i++) begin
      if (exp_clr[i]) begin
        down_d[exp_row[i]][exp_col[i]] = 1'b0;
      end
    end
    if (ev_set) begin
      down_d[key_pos.row][key_pos.col] = 1'b1;
    end
    if (ev_clr) begin
      down_d[key_pos.row][key_pos.col] = 1'b0;
    end
  end

  // Read port: selected row inverted to active-low, plus the any-key summary.
  always_comb begin
    dout_d    = ~down_q[kbd.SEL];
    any_key_d = |down_q;
  end

  // Matrix, VSYNC history and registered outputs.
  always_ff @(posedge CLK12 or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      vsync_q   <= 1'b0;
      down_q    <= '0;
      dout_q    <= 8'hFF;
      any_key_q <= 1'b0;
    end else begin
      vsync_q   <= vsync_d;
      down_q    <= down_d;
      dout_q    <= dout_d;
      any_key_q <= any_key_d;
    end
  end

  assign kbd.DOUT    = dout_q;
  assign kbd.ANY_KEY = any_key_q;

endmodule

// File: tb/tb_homelab_keymatrix.sv
// Scoreboard bench for homelab_keymatrix: directed scenarios then random traffic,
// checked every cycle against a key-level behavioural model.
module tb_homelab_keymatrix;

  localparam int ROWS        = 16;
  localparam int HOLD_SLOTS  = 4;
  localparam int HOLD_FRAMES = 3;
  localparam int NKEYS       = 15;

  logic clk12 = 1'b0;
  logic reset_n;

  homelab_keymatrix_if #(.ROWS(ROWS)) kbd ();

  homelab_keymatrix #(
    .ROWS        (ROWS),
    .HOLD_SLOTS  (HOLD_SLOTS),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) dut (
    .CLK12   (clk12),
    .RESET_N (reset_n),
    .kbd     (kbd)
  );

  always #5 clk12 = ~clk12;

  typedef struct {
    bit       ext;
    bit [7:0] code;
    bit       hit;
    int       row;
    int       col;
  } key_t;

  typedef struct {
    bit valid;
    int row;
    int col;
    int cnt;
    bit rel;
  } mslot_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] dout;
    logic       any;
  } exp_t;

  key_t   keys [NKEYS];
  bit     down_m [ROWS][8];
  mslot_t slot_m [HOLD_SLOTS];
  bit     prev_vs;
  exp_t   exp_q [$];

  int checks_total  = 0;
  int checks_passed = 0;

  bit rst_lvl;
  bit vsync_lvl;
  int sel_lvl;

  // Keys the bench knows about, with their expected Homelab positions.
  task automatic set_key(input int i, input bit ext, input bit [7:0] code,
                         input bit hit, input int row, input int col);
    keys[i] = '{ext: ext, code: code, hit: hit, row: row, col: col};
  endtask

  task automatic init_keys();
    set_key(0,  1'b0, 8'h1C, 1'b1, 4, 0);  // A
    set_key(1,  1'b0, 8'h32, 1'b1, 4, 1);  // B
    set_key(2,  1'b0, 8'h1B, 1'b1, 6, 2);  // S
    set_key(3,  1'b0, 8'h15, 1'b1, 6, 0);  // Q
    set_key(4,  1'b0, 8'h1D, 1'b1, 6, 6);  // W
    set_key(5,  1'b0, 8'h16, 1'b1, 2, 1);  // 1
    set_key(6,  1'b0, 8'h29, 1'b1, 0, 4);  // space
    set_key(7,  1'b0, 8'h5A, 1'b1, 0, 5);  // enter
    set_key(8,  1'b1, 8'h75, 1'b1, 0, 1);  // up arrow
    set_key(9,  1'b0, 8'h12, 1'b1, 1, 0);  // left shift
    set_key(10, 1'b0, 8'h59, 1'b1, 1, 0);  // right shift
    set_key(11, 1'b0, 8'h1A, 1'b1, 7, 1);  // Z
    set_key(12, 1'b1, 8'h7D, 1'b0, 0, 0);  // PgUp, unmapped
    set_key(13, 1'b0, 8'h76, 1'b0, 0, 0);  // Esc, unmapped
    set_key(14, 1'b1, 8'h1C, 1'b0, 0, 0);  // E0 1C, unmapped
  endtask

  function automatic void model_reset();
    foreach (down_m[r, c]) down_m[r][c] = 1'b0;
    foreach (slot_m[i]) slot_m[i] = '{valid: 1'b0, row: 0, col: 0, cnt: 0, rel: 1'b0};
    prev_vs = 1'b0;
  endfunction

  // One cycle of the key-level model: frame aging first, then the key event.
  function automatic void model_step(input bit strobe, input bit pressed, input int idx, input bit vs);
    bit tick;
    int s;
    int f;
    int r;
    int c;
    tick    = vs && !prev_vs;
    prev_vs = vs;
    if (tick) begin
      for (int i = 0; i < HOLD_SLOTS; i++) begin
        if (slot_m[i].valid) begin
          if (slot_m[i].cnt > 0) slot_m[i].cnt--;
          if (slot_m[i].cnt == 0) begin
            if (slot_m[i].rel) down_m[slot_m[i].row][slot_m[i].col] = 1'b0;
            slot_m[i].valid = 1'b0;
          end
        end
      end
    end
    if (!strobe || !keys[idx].hit) return;
    r = keys[idx].row;
    c = keys[idx].col;
    s = -1;
    f = -1;
    for (int i = 0; i < HOLD_SLOTS; i++) begin
      if (slot_m[i].valid && slot_m[i].row == r && slot_m[i].col == c) s = i;
      if (!slot_m[i].valid && f < 0) f = i;
    end
    if (pressed) begin
      down_m[r][c] = 1'b1;
      if (s >= 0) begin
        slot_m[s].cnt = HOLD_FRAMES;
        slot_m[s].rel = 1'b0;
      end else if (f >= 0) begin
        slot_m[f] = '{valid: 1'b1, row: r, col: c, cnt: HOLD_FRAMES, rel: 1'b0};
      end
    end else begin
      if (s >= 0 && slot_m[s].cnt > 0) slot_m[s].rel = 1'b1;
      else down_m[r][c] = 1'b0;
    end
  endfunction

  function automatic exp_t model_expect(input int sel);
    exp_t e;
    e.sel  = 4'(sel);
    e.dout = 8'hFF;
    e.any  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (down_m[sel][c]) e.dout[c] = 1'b0;
    end
    foreach (down_m[r, c]) begin
      if (down_m[r][c]) e.any = 1'b1;
    end
    return e;
  endfunction

  // Drive one cycle of inputs, queue the response due at the next edge, advance the model.
  task automatic applyStimulus(input bit strobe, input bit pressed, input int idx);
    @(negedge clk12);
    reset_n          = rst_lvl;
    kbd.KEY_STROBE   = strobe;
    kbd.KEY_PRESSED  = pressed;
    kbd.KEY_EXTENDED = keys[idx].ext;
    kbd.KEY_CODE     = keys[idx].code;
    kbd.VSYNC        = vsync_lvl;
    kbd.SEL          = 4'(sel_lvl);
    if (!rst_lvl) model_reset();
    exp_q.push_back(model_expect(sel_lvl));
    if (rst_lvl) model_step(strobe, pressed, idx, vsync_lvl);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 0);
  endtask

  task automatic frame();
    vsync_lvl = 1'b1;
    idle(2);
    vsync_lvl = 1'b0;
    idle(3);
  endtask

  task automatic do_reset();
    vsync_lvl = 1'b0;
    rst_lvl   = 1'b0;
    idle(3);
    rst_lvl   = 1'b1;
    idle(4);
  endtask

  task automatic checkOutput(input exp_t e);
    checks_total++;
    if (kbd.DOUT === e.dout) checks_passed++;
    else $display("[TB] FAIL dout sel=%0d got=%h want=%h t=%0t", e.sel, kbd.DOUT, e.dout, $time);
    checks_total++;
    if (kbd.ANY_KEY === e.any) checks_passed++;
    else $display("[TB] FAIL any_key got=%b want=%b t=%0t", kbd.ANY_KEY, e.any, $time);
  endtask

  // Monitor: the registered outputs are compared just after every active edge.
  always @(posedge clk12) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    init_keys();
    reset_n          = 1'b0;
    kbd.KEY_STROBE   = 1'b0;
    kbd.KEY_PRESSED  = 1'b0;
    kbd.KEY_EXTENDED = 1'b0;
    kbd.KEY_CODE     = 8'h00;
    kbd.VSYNC        = 1'b0;
    kbd.SEL          = 4'd0;
    rst_lvl          = 1'b0;
    vsync_lvl        = 1'b0;
    sel_lvl          = 4;
    model_reset();

    $display("[TB] reset");
    do_reset();

    $display("[TB] tap");
    applyStimulus(1'b1, 1'b1, 0);
    idle(1);
    applyStimulus(1'b1, 1'b0, 0);
    repeat (3) frame();
    idle(2);

    $display("[TB] long hold");
    applyStimulus(1'b1, 1'b1, 0);
    repeat (5) frame();
    applyStimulus(1'b1, 1'b0, 0);
    idle(3);

    $display("[TB] slot overflow");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, k);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, k);
    sel_lvl = 6;
    idle(2);
    repeat (2) frame();
    sel_lvl = 4;
    repeat (2) frame();

    $display("[TB] collision break");
    applyStimulus(1'b1, 1'b1, 0);
    repeat (2) frame();
    vsync_lvl = 1'b1;
    applyStimulus(1'b1, 1'b0, 0);
    idle(1);
    vsync_lvl = 1'b0;
    idle(3);

    $display("[TB] collision make");
    applyStimulus(1'b1, 1'b1, 0);
    repeat (2) frame();
    vsync_lvl = 1'b1;
    applyStimulus(1'b1, 1'b1, 0);
    idle(1);
    vsync_lvl = 1'b0;
    idle(3);
    applyStimulus(1'b1, 1'b0, 0);
    repeat (4) frame();

    $display("[TB] unmapped and shifts");
    sel_lvl = 0;
    applyStimulus(1'b1, 1'b1, 12);
    applyStimulus(1'b1, 1'b1, 14);
    idle(2);
    sel_lvl = 1;
    applyStimulus(1'b1, 1'b1, 9);
    repeat (4) frame();
    applyStimulus(1'b1, 1'b0, 9);
    idle(2);
    applyStimulus(1'b1, 1'b1, 10);
    repeat (4) frame();
    applyStimulus(1'b1, 1'b0, 10);
    idle(2);

    $display("[TB] reset mid-hold");
    sel_lvl = 4;
    applyStimulus(1'b1, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 0);
    frame();
    vsync_lvl = 1'b0;
    rst_lvl   = 1'b0;
    idle(2);
    rst_lvl   = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      sel_lvl = r;
      idle(1);
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        do_reset();
      end
      if ($urandom_range(0, 5) == 0) vsync_lvl = ~vsync_lvl;
      sel_lvl = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, NKEYS - 1));
      end else begin
        idle(1);
      end
    end
    vsync_lvl = 1'b0;
    idle(4);

    repeat (2) @(posedge clk12);
    #3;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
